fpu_op_sequencer: RTL and testbench
===================================

// Module: fpu_op_sequencer
// PURPOSE
//  Bus-master controller that runs one complete FPU operation per host command.
//  It writes operand A, operand B and the opcode into the FPU peripheral register file.
//  It then polls the FPU status register until the busy bit clears, reads the result and returns it to the host.
//  It sits between a command source (CPU or SPI-fed queue) and the FPU's peripheral register port.
// PARAMETERS
//  ADDR_OPA      6'h00  FPU register address of operand A
//  ADDR_OPB      6'h04  FPU register address of operand B
//  ADDR_OP       6'h08  FPU opcode register; a write starts the operation
//  ADDR_STATUS   6'h0C  FPU status register
//  ADDR_RESULT   6'h10  FPU result register
//  BUSY_BIT      0      bit index of the busy flag in the status word
//  TIMEOUT_CYC   1024   max cycles from the opcode write to result read-back; 11-bit counter
// PORTS
//  clk             in   1   clock
//  rst             in   1   synchronous reset, active-high
//  cmd_valid       in   1   host command valid
//  cmd_ready       out  1   sequencer can accept a command (IDLE only)
//  cmd_op          in   4   FPU opcode
//  cmd_a           in   32  operand A
//  cmd_b           in   32  operand B
//  res_valid       out  1   result available
//  res_ready       in   1   host accepts result
//  res_data        out  32  FPU result word; 0 on timeout
//  res_timeout     out  1   qualifies res_data; set if TIMEOUT_CYC expired
//  done_irq        out  1   one-cycle pulse when res_valid rises
//  bus_address     out  6   peripheral register address
//  bus_wdata       out  32  write data to peripheral
//  bus_write_n     out  2   write strobe: 2'b10 = 32-bit write, 2'b11 = idle
//  bus_read_n      out  2   read request: 2'b10 = 32-bit read, 2'b11 = idle
//  bus_rdata       in   32  read data from peripheral
//  bus_data_ready  in   1   read data valid / read complete
// BEHAVIOUR
//  Reset values:
//   - state=IDLE; cmd_ready=1; res_valid=0; res_data=0; res_timeout=0; done_irq=0.
//   - bus_write_n=bus_read_n=2'b11; bus_address=0; bus_wdata=0.
//  Capture: cmd_valid&cmd_ready latches op/a/b into internal registers; host may change inputs afterwards.
//  FSM: IDLE -> WR_A -> WR_B -> WR_OP -> RD_STAT -> (RD_RES | RD_STAT) -> RESP -> IDLE.
//  Writes (WR_A/WR_B/WR_OP):
//   - Exactly one cycle each with bus_write_n=2'b10 and matching address/data.
//   - Writes always complete in that cycle; data_ready is not waited for.
//   - WR_OP writes {28'b0, op}.
//  Reads (RD_STAT/RD_RES):
//   - Hold bus_read_n=2'b10 and address until bus_data_ready=1.
//   - Sample bus_rdata in that same cycle, then deassert next cycle (or re-issue for a new read).
//  RD_STAT:
//   - If the sampled busy bit is 1, re-issue the status read the next cycle.
//   - If 0, go to RD_RES.
//  RD_RES: the sampled word goes to res_data with res_timeout=0, then RESP.
//  RESP:
//   - res_valid=1 held until res_ready; done_irq pulses on the entry cycle only.
//   - On res_valid&res_ready go to IDLE with res_valid=0; cmd_ready=1 from the next cycle.
//  Latency with zero-wait FPU (data_ready same cycle, not busy):
//   - Accept at cycle N; writes at N+1..N+3; status read N+4; result read N+5; res_valid at N+6.
//  Timeout:
//   - Counter clears in WR_OP and increments every cycle in RD_STAT/RD_RES.
//   - When it reaches TIMEOUT_CYC: abandon the read (read_n=11 next cycle), go to RESP with res_data=0 and res_timeout=1.
//   - Timeout has priority over a data_ready arriving in the same cycle.
//  bus_data_ready while no read is outstanding: ignored.
//  cmd_valid while not IDLE: ignored; cmd_ready=0, no queueing.
//  Reset mid-operation:
//   - Immediate return to reset values; no bus access is completed or issued after rst.
//   - The FPU is not reset by this block.
//  Only one bus strobe (write_n or read_n) is ever active in a cycle.
// TESTING
//  1) op=1, a=32'h3F800000, b=32'h40000000, FPU never busy, zero-wait reads
//     -> writes to 00/04/08 on consecutive cycles, res_valid at N+6, res_data=32'h40400000.
//  2) FPU busy for 5 status reads
//     -> 6 status reads issued back-to-back, then one result read, res_timeout=0.
//  3) FPU stuck busy -> res_valid with res_timeout=1 and res_data=0.
//     res_valid rises TIMEOUT_CYC cycles after WR_OP, plus one cycle; bus_read_n returns to 11.
//  4) res_ready held low 10 cycles, cmd_valid pulsed meanwhile
//     -> res_valid and res_data stable, cmd_ready=0, command ignored, done_irq a single pulse.
//  5) rst asserted during RD_STAT with data_ready pending
//     -> next cycle: IDLE, bus strobes 11, res_valid=0, cmd_ready=1.
//  6) data_ready delayed 3 cycles on each read
//     -> read_n and address held steady for 4 cycles per read, correct result returned.

Source files
------------

// File: rtl/fpu_op_sequencer_if.sv
`default_nettype none
// ============================================================================
// fpu_op_sequencer_if : host command/result handshake plus FPU register bus
// Revision: 1.0
// ============================================================================
interface fpu_op_sequencer_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_op;
    logic [31:0] cmd_a;
    logic [31:0] cmd_b;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic        res_timeout;
    logic        done_irq;
    logic [5:0]  bus_address;
    logic [31:0] bus_wdata;
    logic [1:0]  bus_write_n;
    logic [1:0]  bus_read_n;
    logic [31:0] bus_rdata;
    logic        bus_data_ready;

    modport master (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, res_ready, bus_rdata, bus_data_ready,
        output cmd_ready, res_valid, res_data, res_timeout, done_irq,
               bus_address, bus_wdata, bus_write_n, bus_read_n
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_a, cmd_b, res_ready, bus_rdata, bus_data_ready,
        input  cmd_ready, res_valid, res_data, res_timeout, done_irq,
               bus_address, bus_wdata, bus_write_n, bus_read_n
    );
endinterface
`default_nettype wire

// File: rtl/fpu_op_sequencer.sv
`default_nettype none
// ============================================================================
// fpu_op_sequencer : writes A/B/opcode to the FPU, polls busy, returns result
// Revision: 1.0
// ============================================================================
module fpu_op_sequencer #(
    parameter logic [5:0] ADDR_OPA    = 6'h00,
    parameter logic [5:0] ADDR_OPB    = 6'h04,
    parameter logic [5:0] ADDR_OP     = 6'h08,
    parameter logic [5:0] ADDR_STATUS = 6'h0C,
    parameter logic [5:0] ADDR_RESULT = 6'h10,
    parameter int         BUSY_BIT    = 0,
    parameter int         TIMEOUT_CYC = 1024
) (
    input logic                clk,
    input logic                rst,
    fpu_op_sequencer_if.master sif
);

    localparam logic [1:0]  c_STROBE_ON  = 2'b10;
    localparam logic [1:0]  c_STROBE_OFF = 2'b11;
    // Last counter value before expiry, so RESP is entered exactly TIMEOUT_CYC+1 cycles after WR_OP
    localparam logic [10:0] c_TO_LAST    = 11'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR_A    = 3'd1,
        S_WR_B    = 3'd2,
        S_WR_OP   = 3'd3,
        S_RD_STAT = 3'd4,
        S_RD_RES  = 3'd5,
        S_RESP    = 3'd6
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [10:0] r_cnt;
    logic [31:0] r_res_data;
    logic        r_res_timeout;
    logic        r_done_irq;
    logic        w_reading;
    logic        w_timeout;

    assign w_reading = (r_state == S_RD_STAT) || (r_state == S_RD_RES);
    assign w_timeout = w_reading && (r_cnt == c_TO_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_op          <= '0;
            r_a           <= '0;
            r_b           <= '0;
            r_cnt         <= '0;
            r_res_data    <= '0;
            r_res_timeout <= 1'b0;
            r_done_irq    <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_done_irq <= (w_next == S_RESP) && (r_state != S_RESP);
            if (r_state == S_IDLE && sif.cmd_valid) begin
                r_op <= sif.cmd_op;
                r_a  <= sif.cmd_a;
                r_b  <= sif.cmd_b;
            end
            if (r_state == S_WR_OP) begin
                r_cnt <= '0;
            end else if (w_reading) begin
                r_cnt <= r_cnt + 11'd1;
            end
            // Timeout wins over a read completing in the same cycle
            if (w_timeout) begin
                r_res_data    <= '0;
                r_res_timeout <= 1'b1;
            end else if (r_state == S_RD_RES && sif.bus_data_ready) begin
                r_res_data    <= sif.bus_rdata;
                r_res_timeout <= 1'b0;
            end
        end
    end

    always_comb begin
        w_next          = r_state;
        sif.cmd_ready   = 1'b0;
        sif.bus_write_n = c_STROBE_OFF;
        sif.bus_read_n  = c_STROBE_OFF;
        sif.bus_address = '0;
        sif.bus_wdata   = '0;
        unique case (r_state)
            S_IDLE: begin
                sif.cmd_ready = 1'b1;
                if (sif.cmd_valid) w_next = S_WR_A;
            end
            S_WR_A: begin
                sif.bus_write_n = c_STROBE_ON;
                sif.bus_address = ADDR_OPA;
                sif.bus_wdata   = r_a;
                w_next          = S_WR_B;
            end
            S_WR_B: begin
                sif.bus_write_n = c_STROBE_ON;
                sif.bus_address = ADDR_OPB;
                sif.bus_wdata   = r_b;
                w_next          = S_WR_OP;
            end
            S_WR_OP: begin
                sif.bus_write_n = c_STROBE_ON;
                sif.bus_address = ADDR_OP;
                sif.bus_wdata   = {28'b0, r_op};
                w_next          = S_RD_STAT;
            end
            S_RD_STAT: begin
                sif.bus_read_n  = c_STROBE_ON;
                sif.bus_address = ADDR_STATUS;
                if (w_timeout) begin
                    w_next = S_RESP;
                end else if (sif.bus_data_ready && !sif.bus_rdata[BUSY_BIT]) begin
                    w_next = S_RD_RES;
                end
            end
            S_RD_RES: begin
                sif.bus_read_n  = c_STROBE_ON;
                sif.bus_address = ADDR_RESULT;
                if (w_timeout || sif.bus_data_ready) w_next = S_RESP;
            end
            S_RESP: begin
                if (sif.res_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign sif.res_valid   = (r_state == S_RESP);
    assign sif.res_data    = r_res_data;
    assign sif.res_timeout = r_res_timeout;
    assign sif.done_irq    = r_done_irq;

endmodule
`default_nettype wire

// File: tb/tb_fpu_op_sequencer.sv
`default_nettype none
// ============================================================================
// tb_fpu_op_sequencer : directed bench with a small FPU register-port responder
// Revision: 1.0
// ============================================================================
module tb_fpu_op_sequencer;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_err    = 0;

    // Peripheral responder controls
    int          rd_delay  = 0;
    int          busy_cnt  = 0;
    bit          stuck     = 1'b0;
    bit          force_dr  = 1'b0;
    logic [31:0] result_val = '0;
    int          p_wait;

    fpu_op_sequencer_if sif ();

    fpu_op_sequencer dut (
        .clk (clk),
        .rst (rst),
        .sif (sif)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst || sif.bus_read_n != 2'b10 || sif.bus_data_ready) p_wait <= 0;
        else p_wait <= p_wait + 1;
        if (sif.bus_read_n == 2'b10 && sif.bus_data_ready && sif.bus_address == 6'h0C && busy_cnt != 0)
            busy_cnt <= busy_cnt - 1;
    end

    always_comb begin
        sif.bus_data_ready = force_dr || (sif.bus_read_n == 2'b10 && p_wait == rd_delay);
        sif.bus_rdata      = (sif.bus_address == 6'h0C) ? {31'b0, (stuck || busy_cnt != 0)} : result_val;
    end

    initial begin
        #200us;
        $display("FAIL watchdog: observed=no_finish expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Presents one command for one cycle, then scrambles the host inputs
    task automatic issue_cmd(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        sif.cmd_valid = 1'b1;
        sif.cmd_op    = op;
        sif.cmd_a     = a;
        sif.cmd_b     = b;
        tick();
        sif.cmd_valid = 1'b0;
        sif.cmd_op    = 4'hF;
        sif.cmd_a     = 32'hDEADBEEF;
        sif.cmd_b     = 32'hCAFEF00D;
    endtask

    // Runs from WR_A until res_valid, counting cycles and read activity
    task automatic wait_resp(input int budget, output int cycles, output int stat_rd,
                             output int res_rd, output int stat_cyc, output int res_cyc);
        cycles = 0; stat_rd = 0; res_rd = 0; stat_cyc = 0; res_cyc = 0;
        while (cycles < budget && !sif.res_valid) begin
            if (sif.bus_read_n == 2'b10 && sif.bus_address == 6'h0C) begin
                stat_cyc++;
                if (sif.bus_data_ready) stat_rd++;
            end
            if (sif.bus_read_n == 2'b10 && sif.bus_address == 6'h10) begin
                res_cyc++;
                if (sif.bus_data_ready) res_rd++;
            end
            tick();
            cycles++;
        end
    endtask

    initial begin
        int cyc, srd, rrd, scyc, rcyc, irq_cnt, unstable;
        rst = 1'b1;
        sif.cmd_valid = 1'b0;
        sif.cmd_op    = '0;
        sif.cmd_a     = '0;
        sif.cmd_b     = '0;
        sif.res_ready = 1'b0;
        tick();
        tick();
        chk("rst_cmd_ready", 32'(sif.cmd_ready), 32'd1);
        chk("rst_res_valid", 32'(sif.res_valid), 32'd0);
        chk("rst_res_data", sif.res_data, 32'd0);
        chk("rst_res_timeout", 32'(sif.res_timeout), 32'd0);
        chk("rst_done_irq", 32'(sif.done_irq), 32'd0);
        chk("rst_write_n", 32'(sif.bus_write_n), 32'd3);
        chk("rst_read_n", 32'(sif.bus_read_n), 32'd3);
        chk("rst_address", 32'(sif.bus_address), 32'd0);
        chk("rst_wdata", sif.bus_wdata, 32'd0);
        rst = 1'b0;
        tick();

        // 1) zero-wait FPU, exact per-cycle bus sequence
        result_val = 32'h40400000;
        issue_cmd(4'h1, 32'h3F800000, 32'h40000000);
        chk("t1_wa_wn", 32'(sif.bus_write_n), 32'd2);
        chk("t1_wa_addr", 32'(sif.bus_address), 32'h00);
        chk("t1_wa_data", sif.bus_wdata, 32'h3F800000);
        chk("t1_wa_rn", 32'(sif.bus_read_n), 32'd3);
        chk("t1_wa_ready", 32'(sif.cmd_ready), 32'd0);
        tick();
        chk("t1_wb_addr", 32'(sif.bus_address), 32'h04);
        chk("t1_wb_data", sif.bus_wdata, 32'h40000000);
        tick();
        chk("t1_wop_addr", 32'(sif.bus_address), 32'h08);
        chk("t1_wop_data", sif.bus_wdata, 32'h00000001);
        chk("t1_wop_wn", 32'(sif.bus_write_n), 32'd2);
        tick();
        chk("t1_rs_rn", 32'(sif.bus_read_n), 32'd2);
        chk("t1_rs_wn", 32'(sif.bus_write_n), 32'd3);
        chk("t1_rs_addr", 32'(sif.bus_address), 32'h0C);
        tick();
        chk("t1_rr_addr", 32'(sif.bus_address), 32'h10);
        chk("t1_rr_rn", 32'(sif.bus_read_n), 32'd2);
        tick();
        chk("t1_res_valid", 32'(sif.res_valid), 32'd1);
        chk("t1_res_data", sif.res_data, 32'h40400000);
        chk("t1_res_timeout", 32'(sif.res_timeout), 32'd0);
        chk("t1_done_irq", 32'(sif.done_irq), 32'd1);
        chk("t1_resp_rn", 32'(sif.bus_read_n), 32'd3);
        sif.res_ready = 1'b1;
        tick();
        sif.res_ready = 1'b0;
        chk("t1_idle_valid", 32'(sif.res_valid), 32'd0);
        chk("t1_idle_ready", 32'(sif.cmd_ready), 32'd1);
        chk("t1_idle_irq", 32'(sif.done_irq), 32'd0);

        // 2) busy for five status reads
        busy_cnt   = 5;
        result_val = 32'h12345678;
        issue_cmd(4'h2, 32'h1, 32'h2);
        wait_resp(100, cyc, srd, rrd, scyc, rcyc);
        chk("t2_res_valid", 32'(sif.res_valid), 32'd1);
        chk("t2_stat_reads", 32'(srd), 32'd6);
        chk("t2_res_reads", 32'(rrd), 32'd1);
        chk("t2_cycles", 32'(cyc), 32'd10);
        chk("t2_res_data", sif.res_data, 32'h12345678);
        chk("t2_res_timeout", 32'(sif.res_timeout), 32'd0);
        sif.res_ready = 1'b1;
        tick();
        sif.res_ready = 1'b0;

        // 6) three wait states on every read
        rd_delay   = 3;
        result_val = 32'hA5A55A5A;
        issue_cmd(4'h3, 32'h3, 32'h4);
        wait_resp(100, cyc, srd, rrd, scyc, rcyc);
        chk("t6_res_valid", 32'(sif.res_valid), 32'd1);
        chk("t6_stat_hold", 32'(scyc), 32'd4);
        chk("t6_res_hold", 32'(rcyc), 32'd4);
        chk("t6_cycles", 32'(cyc), 32'd11);
        chk("t6_res_data", sif.res_data, 32'hA5A55A5A);
        sif.res_ready = 1'b1;
        tick();
        sif.res_ready = 1'b0;
        rd_delay = 0;

        // 3) stuck busy -> timeout
        stuck = 1'b1;
        issue_cmd(4'h4, 32'h5, 32'h6);
        wait_resp(2000, cyc, srd, rrd, scyc, rcyc);
        chk("t3_res_valid", 32'(sif.res_valid), 32'd1);
        chk("t3_cycles", 32'(cyc), 32'd1027);
        chk("t3_res_timeout", 32'(sif.res_timeout), 32'd1);
        chk("t3_res_data", sif.res_data, 32'd0);
        chk("t3_read_n", 32'(sif.bus_read_n), 32'd3);
        chk("t3_res_reads", 32'(rrd), 32'd0);

        // 4) host stalls the result ten cycles while pulsing cmd_valid
        irq_cnt  = sif.done_irq ? 1 : 0;
        unstable = 0;
        for (int i = 0; i < 10; i++) begin
            sif.cmd_valid = (i == 3);
            tick();
            if (sif.done_irq) irq_cnt++;
            if (!sif.res_valid || sif.res_data !== 32'd0 || sif.res_timeout !== 1'b1 ||
                sif.cmd_ready || sif.bus_write_n !== 2'b11 || sif.bus_read_n !== 2'b11)
                unstable++;
        end
        sif.cmd_valid = 1'b0;
        chk("t4_irq_pulses", 32'(irq_cnt), 32'd1);
        chk("t4_unstable_cycles", 32'(unstable), 32'd0);
        stuck = 1'b0;
        sif.res_ready = 1'b1;
        tick();
        sif.res_ready = 1'b0;
        chk("t4_idle_ready", 32'(sif.cmd_ready), 32'd1);
        tick();
        chk("t4_cmd_dropped", 32'(sif.bus_write_n), 32'd3);

        // 5) reset while a status read completes
        busy_cnt = 100;
        issue_cmd(4'h5, 32'h7, 32'h8);
        tick();
        tick();
        tick();
        chk("t5_in_rd_stat", 32'(sif.bus_read_n), 32'd2);
        chk("t5_dr_pending", 32'(sif.bus_data_ready), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        busy_cnt = 0;
        chk("t5_read_n", 32'(sif.bus_read_n), 32'd3);
        chk("t5_write_n", 32'(sif.bus_write_n), 32'd3);
        chk("t5_res_valid", 32'(sif.res_valid), 32'd0);
        chk("t5_cmd_ready", 32'(sif.cmd_ready), 32'd1);
        chk("t5_address", 32'(sif.bus_address), 32'd0);

        // stray data_ready while idle is ignored
        force_dr = 1'b1;
        tick();
        force_dr = 1'b0;
        tick();
        chk("stray_dr_ready", 32'(sif.cmd_ready), 32'd1);
        chk("stray_dr_valid", 32'(sif.res_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
